os_16bit_20_src: RTL
====================

// Module: os_16bit_20_src
// PURPOSE
//  Producer side of the os_16bit_20 operand interface. Accepts two 8-bit GF(2) polynomials a, b and a
//  16-bit addend d, then computes the carry-less product a*b serially, one bit of b per cycle.
//  Presents z0/z1/z2/o registered and stable under a valid/ready handshake for the downstream XOR3
//  recombination stage.
//  Output mapping: z1 = clmul(a,b) (15b), z0 = d[7:0], z2 = d[15:8], o = z1[14:8] (fold term).
// PARAMETERS
//  W      8   operand width; z1 width = 2*W-1, o width = W-1; this block is verified at W=8 only
//  CNT_W  3   iteration counter width = clog2(W)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  in_valid   in   1   operands a/b/d valid
//  in_ready   out  1   block can accept operands (IDLE only)
//  a          in   8   multiplicand polynomial
//  b          in   8   multiplier polynomial, consumed LSB first
//  d          in   16  addend, split into z0/z2
//  out_valid  out  1   z0/z1/z2/o valid
//  out_ready  in   1   downstream accepts result
//  z0         out  8   d[7:0] of the accepted transaction
//  z1         out  15  carry-less product a*b
//  z2         out  8   d[15:8] of the accepted transaction
//  o          out  7   z1[14:8]
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk deassert upstream): state=IDLE, cnt=0, acc=0, all data regs=0.
//    Outputs: in_ready=1, out_valid=0, z0=z1=z2=o=0, busy=0.
//  - FSM states IDLE, MUL, HOLD.
//    IDLE: in_ready=1. On in_valid at edge k:
//      latch a, b, d; acc<=0; cnt<=0; go to MUL.
//    MUL: at each edge, if b_reg[cnt] is set, acc ^= (a_reg << cnt). cnt increments; cnt wraps 7->0.
//      After the 8th MUL edge (k+8), go to HOLD.
//    HOLD: out_valid=1. z1=acc[14:0]; o=acc[14:8]; z0/z2 come from the latched d.
//      On out_ready go to IDLE. Outputs stay stable while out_ready=0, for any number of cycles.
//  - Latency: out_valid first high in the cycle after edge k+8. Minimum throughput is 1 result per
//    10 cycles. IDLE and HOLD do not overlap, so there is no accept on the same edge as a result handoff.
//  - in_valid during MUL/HOLD is ignored (in_ready=0). Operand inputs are sampled only at the accept edge.
//  - Reset asserted mid-MUL or mid-HOLD aborts the transaction immediately. No partial result is emitted.
//  - Arithmetic is XOR only, with no carries. acc is 15b and a_reg<<cnt never exceeds bit 14.
//  - Data outputs are zero outside HOLD, so downstream never sees a partial acc.
// STRUCTURE
//  - Shared package os_pkg: localparams OS_W=8, OS_PROD_W=15, OS_FOLD_W=7, and the
//    typedef enum logic [1:0] {OS_IDLE, OS_MUL, OS_HOLD} os_state_t.
//  - One sub-module, os_clmul8_serial: holds a_reg, b_reg, acc and cnt.
//    Inputs: start, step. Outputs: acc, last (cnt==7 during step).
//  - Top level holds the FSM, the handshake, the d register and the output muxing.
// TESTING
//  1. Reset: hold rst_n=0 -> in_ready=1, out_valid=0, busy=0, all data outputs 0.
//  2. a=0x03, b=0x03, d=0xA55A, out_ready=1 -> out_valid exactly 8 edges after accept;
//     z1=0x0005, o=0x00, z0=0x5A, z2=0xA5; IDLE next cycle.
//  3. a=0xFF, b=0xFF -> z1=0x5555, o=0x55.
//     a=0x80, b=0x80 -> z1=0x4000, o=0x40.
//     a=0x00, b=0xFF -> z1=0, o=0.
//  4. Back-pressure: out_ready=0 for 20 cycles in HOLD -> outputs stable, in_ready=0, new in_valid
//     ignored; out_ready=1 -> single handoff, then in_ready=1.
//  5. Reset mid-MUL (cycle 4) -> out_valid never asserts; the next transaction a=0x05, b=0x03
//     gives z1=0x000F.
//  6. Feed the outputs into os_16bit_20 and compare y against the reference model
//     y[i] = z1[i]^z0[i]^o[i] etc. for 1000 random transactions.

Source files
------------

// File: rtl/os_pkg.sv
// os_pkg: shared widths and FSM state encoding for the os_16bit_20 operand producer
package os_pkg;
    localparam int OS_W      = 8;
    localparam int OS_CNT_W  = 3;
    localparam int OS_PROD_W = 2 * OS_W - 1;
    localparam int OS_FOLD_W = OS_W - 1;
    typedef enum logic [1:0] {OS_IDLE, OS_MUL, OS_HOLD} os_state_t;
endpackage

// File: rtl/os_clmul8_serial.sv
// os_clmul8_serial: shift-and-XOR carry-less multiplier consuming one bit of b per step
module os_clmul8_serial
    import os_pkg::*;
#(
    parameter int W     = OS_W,
    parameter int CNT_W = OS_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [2*W-2:0]   acc,
    output logic             last
);
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [2*W-2:0] acc_q, acc_d, a_ext;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // start latches operands and clears the product; each step folds in a << cnt when b[cnt] is set
    always_comb begin
        a_ext = {{(W-1){1'b0}}, a_q};
        a_d   = start ? a : a_q;
        b_d   = start ? b : b_q;
        acc_d = start ? '0 : (step && b_q[cnt_q]) ? acc_q ^ (a_ext << cnt_q) : acc_q;
        cnt_d = start ? '0 : step ? cnt_q + 1'b1 : cnt_q;
    end

    // operand, accumulator and bit-index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc  = acc_q;
    assign last = step && (cnt_q == CNT_W'(W - 1));
endmodule

// File: rtl/os_16bit_20_src.sv
// os_16bit_20_src: handshaked producer of z0/z1/z2/o for the XOR3 recombination stage
module os_16bit_20_src
    import os_pkg::*;
#(
    parameter int W     = OS_W,
    parameter int CNT_W = OS_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [2*W-1:0]   d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     z0,
    output logic [2*W-2:0]   z1,
    output logic [W-1:0]     z2,
    output logic [W-2:0]     o,
    output logic             busy
);
    os_state_t        state_q, state_d;
    logic [2*W-1:0]   d_q, d_d;
    logic [2*W-2:0]   acc;
    logic             start, step, last;

    os_clmul8_serial #(.W(W), .CNT_W(CNT_W)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .step  (step),
        .a     (a),
        .b     (b),
        .acc   (acc),
        .last  (last)
    );

    // IDLE accepts, MUL runs W steps, HOLD presents the result until the consumer takes it
    always_comb begin
        start   = (state_q == OS_IDLE) && in_valid;
        step    = state_q == OS_MUL;
        d_d     = start ? d : d_q;
        state_d = start ? OS_MUL
                : last ? OS_HOLD
                : (state_q == OS_HOLD && out_ready) ? OS_IDLE
                : state_q;
    end

    // state and addend registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OS_IDLE;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
        end
    end

    // handshake decoded from state; data forced to zero outside HOLD so a partial acc never leaks
    assign in_ready  = state_q == OS_IDLE;
    assign out_valid = state_q == OS_HOLD;
    assign busy      = state_q != OS_IDLE;
    assign z1        = out_valid ? acc : '0;
    assign z0        = out_valid ? d_q[W-1:0] : '0;
    assign z2        = out_valid ? d_q[2*W-1:W] : '0;
    assign o         = z1[2*W-2:W];
endmodule
